// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit words into a byte-wide big-endian instruction memory
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   start                  begin a load (sampled only in IDLE)
//   base_addr, word_count  load base byte address and word count, latched with start
//   in_valid, in_data      upstream word stream
//   in_ready               loader accepts in_data this cycle
//   mem_we, mem_addr,      single-byte write port to the instruction memory
//   mem_wdata
//   busy                   load in progress, core must stall
//   done                   one-cycle pulse at the end of every load, including rejected ones
//   error                  sticky reject flag, cleared by the next accepted start
module imem_loader #(
    parameter int MEM_BYTES = 64,
    parameter int COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        IDLE, CHECK, WAIT_WORD, WR0, WR1, WR2, WR3, FIN
    } state_t;

    state_t             state;
    logic [31:0]        ptr;
    logic [COUNT_W-1:0] remain;
    logic [31:0]        word;

    // End address of the load, widened so base + 4*count cannot wrap.
    logic [33:0] end_addr;
    logic        bad_load;

    assign end_addr = {2'b00, ptr} + {{(32 - COUNT_W){1'b0}}, remain, 2'b00};
    assign bad_load = (ptr[1:0] != 2'b00) || (end_addr > 34'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remain    <= '0;
            word      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ptr    <= base_addr;
                        remain <= word_count;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_load || remain == '0) begin
                        error <= bad_load;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (in_valid) begin
                        // Outputs are registered, so the WR0 byte is
                        // presented on the same edge the word is taken.
                        word      <= in_data;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data[31:24];
                        state     <= WR0;
                    end
                end
                WR0: begin
                    mem_addr  <= ptr + 32'd1;
                    mem_wdata <= word[23:16];
                    state     <= WR1;
                end
                WR1: begin
                    mem_addr  <= ptr + 32'd2;
                    mem_wdata <= word[15:8];
                    state     <= WR2;
                end
                WR2: begin
                    mem_addr  <= ptr + 32'd3;
                    mem_wdata <= word[7:0];
                    state     <= WR3;
                end
                WR3: begin
                    mem_we <= 1'b0;
                    ptr    <= ptr + 32'd4;
                    remain <= remain - 1'b1;
                    if (remain == COUNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= WAIT_WORD;
                    end
                end
                FIN: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  word_count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, mem_we, busy, done, error;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [39:0] exp_q[$];   // {addr[31:0], data[7:0]}

    imem_loader #(.MEM_BYTES(64), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: every byte write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata}, 40'hFFFFFFFFFF);
            end else begin
                check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
        if (rst_n && in_ready)
            check("ready_only_waiting", {38'd0, mem_we, busy}, 40'd1);
    end

    task automatic push_word(input logic [31:0] addr, input logic [31:0] w);
        exp_q.push_back({addr,         w[31:24]});
        exp_q.push_back({addr + 32'd1, w[23:16]});
        exp_q.push_back({addr + 32'd2, w[15:8]});
        exp_q.push_back({addr + 32'd3, w[7:0]});
    endtask

    task automatic start_load(input logic [31:0] b, input logic [7:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents a word after 'gap' idle cycles and holds it until accepted.
    task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        push_word(addr, w);
        in_valid = 1'b1; in_data = w;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("accept_timeout", {39'd0, ok}, 40'd1);
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (done) ok = 1;
            else begin @(posedge clk); #1; end
        end
        check({tag, "_done"}, {39'd0, ok}, 40'd1);
        check({tag, "_fin_flags"}, {37'd0, busy, mem_we, error}, {37'd0, 2'b00, exp_err});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {39'd0, done}, 40'd0);
        check({tag, "_queue_empty"}, 40'(exp_q.size()), 40'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
        check("ready_timeout", {39'd0, in_ready}, 40'd1);
    endtask

    int d0;

    initial begin
        // Reset state
        #12;
        check("reset_flags", {34'd0, in_ready, mem_we, busy, done, error, 1'b0}, 40'd0);
        check("reset_bus", {mem_addr, mem_wdata}, 40'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single word at base 0
        d0 = done_cnt;
        start_load(32'd0, 8'd1);
        check("s1_busy", {39'd0, busy}, 40'd1);
        send_word(32'd0, 32'h8C010004, 0);
        wait_done("s1", 1'b0);
        check("s1_done_count", 40'(done_cnt - d0), 40'd1);

        // 2: three words with upstream gaps
        d0 = done_cnt;
        start_load(32'd8, 8'd3);
        send_word(32'd8,  32'h11223344, 0);
        send_word(32'd12, 32'hA5B6C7D8, 2);
        send_word(32'd16, 32'hDEADBEEF, 2);
        wait_done("s2", 1'b0);
        check("s2_done_count", 40'(done_cnt - d0), 40'd1);

        // 3: range error, done two cycles after the start edge
        start_load(32'd60, 8'd2);
        check("s3_check_cycle", {38'd0, busy, done}, 40'd2);
        @(posedge clk); #1;
        check("s3_range_done", {38'd0, done, error}, 40'd3);
        wait_done("s3r", 1'b1);
        // misaligned base
        start_load(32'd2, 8'd1);
        check("s3_err_cleared_on_start", {39'd0, error}, 40'd0);
        @(posedge clk); #1;
        check("s3_align_done", {38'd0, done, error}, 40'd3);
        wait_done("s3a", 1'b1);
        // legal start clears error on its edge
        start_load(32'd4, 8'd1);
        check("s3_err_clear", {39'd0, error}, 40'd0);
        send_word(32'd4, 32'h01020304, 0);
        wait_done("s3l", 1'b0);

        // 4: zero count, then boundary fill
        start_load(32'd20, 8'd0);
        wait_done("s4z", 1'b0);
        start_load(32'd60, 8'd1);
        send_word(32'd60, 32'hCAFEF00D, 1);
        wait_done("s4b", 1'b0);

        // 5: start during WR1 is ignored
        d0 = done_cnt;
        start_load(32'd16, 8'd1);
        wait_ready();
        push_word(32'd16, 32'h76543210);
        in_valid = 1'b1; in_data = 32'h76543210;
        @(posedge clk); #1;                 // now in WR0
        in_valid = 1'b0;
        @(posedge clk); #1;                 // now in WR1
        check("s5_in_wr1", {mem_addr, mem_wdata}, {32'd17, 8'h54});
        start_load(32'd40, 8'd2);
        wait_done("s5", 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("s5_done_count", 40'(done_cnt - d0), 40'd1);
        check("s5_idle", {38'd0, busy, mem_we}, 40'd0);

        // 6: async reset during WR2
        d0 = done_cnt;
        start_load(32'd32, 8'd2);
        wait_ready();
        push_word(32'd32, 32'h0F1E2D3C);
        in_valid = 1'b1; in_data = 32'h0F1E2D3C;
        @(posedge clk); #1;                 // WR0
        in_valid = 1'b0;
        @(posedge clk); #1;                 // WR1
        @(posedge clk); #1;                 // WR2
        check("s6_in_wr2", {mem_we, busy, mem_addr[5:0], mem_wdata, 24'd0},
              {1'b1, 1'b1, 6'd34, 8'h2D, 24'd0});
        rst_n = 1'b0;
        #1;
        check("s6_async_drop", {37'd0, mem_we, busy, done}, 40'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("s6_no_done", 40'(done_cnt - d0), 40'd0);
        start_load(32'd0, 8'd1);
        send_word(32'd0, 32'h8C010004, 0);
        wait_done("s6", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the byte-addressed, big-endian instruction memory, which is read one 32-bit word per clock as four bytes at addr..addr+3, MSB first.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake.
- Writes each word into the byte array as four single-byte writes, big-endian, at consecutive addresses from a programmed base.
- Holds `busy` high while loading so the CPU core can be stalled; reports completion and range/alignment errors.

Parameters:
- MEM_BYTES, 64: byte capacity of the target instruction memory; valid byte addresses are 0..MEM_BYTES-1.
- COUNT_W, 8: width of the word-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load; sampled only when not busy.
- base_addr  input  32  first byte address of the load; sampled with start.
- word_count  input  COUNT_W  number of 32-bit words to load; sampled with start.
- in_valid  input  1  in_data holds a word.
- in_data  input  32  instruction word.
- in_ready  output  1  loader can accept in_data this cycle.
- mem_we  output  1  byte write enable to the instruction memory.
- mem_addr  output  32  byte address for the write.
- mem_wdata  output  8  byte written.
- busy  output  1  load in progress; the core must stall.
- done  output  1  one-cycle pulse at the end of a load, including aborted loads.
- error  output  1  sticky; set when a load is rejected, cleared on the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE.
  - in_ready, mem_we, busy, done and error go to 0; mem_addr and mem_wdata go to 0.
  - Takes effect immediately, including mid-word; any partially written word is left as is.
- All outputs are registered.
- States: IDLE, CHECK, WAIT_WORD, WR0, WR1, WR2, WR3, FIN.
- IDLE:
  - start=1 latches base_addr and word_count and moves to CHECK.
  - error clears on that edge.
- CHECK (busy=1, one cycle). Reject the load when either holds:
  - base_addr[1:0] != 0;
  - base_addr + 4*word_count > MEM_BYTES, computed at 33+ bits so no wrap.
  - Reject: error=1, go to FIN with no writes.
  - word_count=0 with a legal base: go to FIN with no writes and no error.
  - Otherwise go to WAIT_WORD.
- WAIT_WORD (busy=1):
  - in_ready=1.
  - On an edge with in_valid && in_ready, latch in_data, drop in_ready and go to WR0.
- WR0..WR3 (busy=1, in_ready=0): one byte per cycle, mem_we=1.

  | State | mem_addr | mem_wdata |
  |---|---|---|
  | WR0 | ptr | word[31:24] |
  | WR1 | ptr+1 | word[23:16] |
  | WR2 | ptr+2 | word[15:8] |
  | WR3 | ptr+3 | word[7:0] |

  - After WR3: ptr += 4 and the remaining count decrements.
  - If words remain, go to WAIT_WORD; else go to FIN.
- Throughput: 5 cycles per word minimum (1 accept cycle + 4 write cycles).
- FIN: done=1 for exactly one cycle, busy=0, mem_we=0, then IDLE.
- start while busy is ignored; start during the FIN cycle is also ignored.
- in_valid while in_ready=0 is ignored; the upstream must hold the word until accepted.
- No write ever targets an address >= MEM_BYTES; this is guaranteed by the CHECK state.

Test Plan:
1. Single word:
   - Stimulus: reset, start with base=0, count=1; word 0x8C010004 presented.
   - Response: mem_we on 4 consecutive cycles with (0,0x8C), (1,0x01), (2,0x00), (3,0x04); done pulse on the next cycle; busy low; error=0.
2. Multi-word with upstream gaps:
   - Stimulus: base=8, count=3; in_valid deasserted for 2 cycles between words.
   - Response: writes at 8..19 in big-endian order; in_ready high only in WAIT_WORD; no writes during the gaps; a single done pulse.
3. Range and alignment errors:
   - Stimulus: base=60, count=2 (end 68 > 64).
     Response: no mem_we; done pulse two cycles after start; error=1.
   - Stimulus: base=2, count=1.
     Response: same, error=1.
   - Stimulus: then a legal start.
     Response: error clears on the start edge.
4. Zero count and boundary fill:
   - Stimulus: count=0.
     Response: done, no writes, error=0.
   - Stimulus: base=60, count=1.
     Response: writes at 60..63, no error.
5. Start while busy:
   - Stimulus: a second start with different base/count during WR1.
   - Response: ignored; original load completes unchanged.
6. Async reset mid-op:
   - Stimulus: rst_n low during WR2.
   - Response: mem_we/busy drop without waiting for a clock edge; no done pulse. After release, a fresh load behaves as in scenario 1.
